ex_div_unit: RTL and testbench

//  Iterative radix-2 divider for RV64M DIV/DIVU/REM/REMU and the W forms.

---
 rtl/ex_div_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_ex_div_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU
// and the W forms (DIVW/DIVUW/REMW/REMUW). Sits in EX behind the ID/EX register.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset
//   start_i   valid divide op present in EX this cycle
//   flush_i   squash the in-flight op (branch redirect / trap)
//   op_i      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   word_i    1 = W form (operate on low XLEN/2 bits, sign-extend result)
//   a_i       dividend (rs1)
//   b_i       divisor (rs2)
//   busy_o    FSM not idle
//   stall_o   holds IF/ID/ID-EX while an op is starting or iterating
//   done_o    one-cycle pulse, result_o valid
//   result_o  quotient or remainder, held until the next done_o
//
// Configuration macro: DIV_EARLY_OUT_EN
//   Defined: divide-by-zero and signed overflow finish one edge after start.
//   Undefined: those cases take the full iterative path; results are identical.

module ex_div_unit #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [1:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned HALF = XLEN / 2;
    localparam int unsigned CW   = $clog2(XLEN) + 1;

    localparam logic [CW-1:0]   ITER_FULL = CW'(XLEN);
    localparam logic [CW-1:0]   ITER_WORD = CW'(HALF);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    // Most negative value, full width and sign-extended 32-bit form.
    localparam logic [XLEN-1:0] MIN_X     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W     = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic            word_q, word_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] div_q, div_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    // Sign-extend the low half to full width for W results.
    function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
        return w ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
    endfunction

    // Operand preparation on the incoming op.
    logic            in_signed;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
    logic            a_neg, b_neg;
    logic            in_div_zero, in_ovf;

    always_comb begin
        in_signed = ~op_i[0];
        if (word_i) begin
            a_ext = in_signed ? {{HALF{a_i[HALF-1]}}, a_i[HALF-1:0]}
                              : {{HALF{1'b0}}, a_i[HALF-1:0]};
            b_ext = in_signed ? {{HALF{b_i[HALF-1]}}, b_i[HALF-1:0]}
                              : {{HALF{1'b0}}, b_i[HALF-1:0]};
        end else begin
            a_ext = a_i;
            b_ext = b_i;
        end
        a_neg       = in_signed & a_ext[XLEN-1];
        b_neg       = in_signed & b_ext[XLEN-1];
        a_mag       = a_neg ? -a_ext : a_ext;
        b_mag       = b_neg ? -b_ext : b_ext;
        in_div_zero = (b_ext == '0);
        in_ovf      = in_signed && (a_ext == (word_i ? MIN_W : MIN_X)) && (b_ext == '1);
    end

`ifdef DIV_EARLY_OUT_EN
    logic [XLEN-1:0] early_result;

    always_comb begin
        if (op_i[1]) begin
            early_result = in_div_zero ? a_ext : '0;
        end else begin
            early_result = in_div_zero ? '1 : (word_i ? MIN_W : MIN_X);
        end
        early_result = wfix(word_i, early_result);
    end
`endif

    // Iteration step and final fix-up.
    logic [XLEN:0]   rem_shift;
    logic            rem_ge;
    logic [XLEN-1:0] rem_sub;
    logic [XLEN-1:0] q_fix, r_fix, fix_result;

    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        rem_ge    = rem_shift >= {1'b0, div_q};
        // When rem_ge holds the true difference is below div_q, so the low bits suffice.
        rem_sub   = rem_shift[XLEN-1:0] - div_q;

        q_fix = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
        if (dz_q) begin
            q_fix = '1;
        end else if (ovf_q) begin
            q_fix = word_q ? MIN_W : MIN_X;
        end
        // Remainder is already right for both special cases: with a zero divisor it
        // ends as |a| (sign restored below), and MIN / -1 leaves zero.
        r_fix      = sign_a_q ? -rem_q : rem_q;
        fix_result = wfix(word_q, op_q[1] ? r_fix : q_fix);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        word_d   = word_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        div_d    = div_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && !flush_i) begin
                    op_d     = op_i;
                    word_d   = word_i;
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    dz_d     = in_div_zero;
                    ovf_d    = in_ovf;
                    div_d    = b_mag;
                    // W dividends sit in the top half so the MSB shift-out works unchanged.
                    quo_d    = word_i ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
                    rem_d    = '0;
                    cnt_d    = word_i ? ITER_WORD : ITER_FULL;
`ifdef DIV_EARLY_OUT_EN
                    if (in_div_zero || in_ovf) begin
                        result_d = early_result;
                        state_d  = StDone;
                    end else begin
                        state_d  = StCalc;
                    end
`else
                    state_d  = StCalc;
`endif
                end
            end
            StCalc: begin
                rem_d = rem_ge ? rem_sub : rem_shift[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], rem_ge};
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = fix_result;
                state_d  = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flush aborts from any state and never updates the visible result.
        if (flush_i) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            op_q     <= '0;
            word_q   <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            div_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            word_q   <= word_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            div_q    <= div_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q != StIdle);
    assign stall_o  = (start_i && (state_q == StIdle)) || (state_q == StCalc) ||
                      (state_q == StFix);
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: table-driven bench for ex_div_unit with a result scoreboard,
// plus hand-written flush and mid-op reset sequences.

module tb_ex_div_unit;

    localparam int unsigned XLEN = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic            clk_i;
    logic            rst_ni;
    logic            start_i;
    logic            flush_i;
    logic [1:0]      op_i;
    logic            word_i;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            busy_o;
    logic            stall_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    ex_div_unit #(.XLEN(XLEN)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .flush_i  (flush_i),
        .op_i     (op_i),
        .word_i   (word_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        bit          special;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] exp_q[$];
    logic [63:0] last_res;
    int          n_cmp;
    int          n_bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic add(input logic [1:0] op, input logic word, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input bit special);
        vec_t v;
        v.op = op; v.word = word; v.a = a; v.b = b; v.exp = exp; v.special = special;
        vecs.push_back(v);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after DONE.
    task automatic run_op(input vec_t v, input string name);
        int          lat;
        int          exp_lat;
        bit          seen;
        bit          stall_ok;
        logic [63:0] want;
        exp_lat = v.word ? 34 : 66;
`ifdef DIV_EARLY_OUT_EN
        if (v.special) exp_lat = 1;
`endif
        op_i = v.op; word_i = v.word; a_i = v.a; b_i = v.b; start_i = 1'b1;
        #1;
        check({name, " stall_on_start"}, stall_o, 1);
        exp_q.push_back(v.exp);
        lat = 0; seen = 0; stall_ok = 1;
        // start_i stays high like a stalled pipeline would hold it; it must be ignored.
        while (!seen && lat < 100) begin
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
            if (done_o) seen = 1;
            else if (!stall_o || !busy_o) stall_ok = 0;
        end
        check({name, " done_seen"}, seen, 1);
        if (seen) begin
            check({name, " latency"}, lat, exp_lat);
            check({name, " stall_while_busy"}, stall_ok, 1);
            check({name, " stall_at_done"}, stall_o, 0);
        end
        start_i = 1'b0;
        check({name, " sb_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            if (seen) begin
                check({name, " result"}, result_o, want);
                last_res = want;
            end
        end
        @(negedge clk_i);
        check({name, " done_one_cycle"}, done_o, 0);
        check({name, " result_held"}, result_o, last_res);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   done_cnt;
        n_cmp = 0; n_bad = 0; last_res = '0;
        start_i = 0; flush_i = 0; op_i = 0; word_i = 0; a_i = 0; b_i = 0;
        rst_ni = 0;

        // op: 0 DIV, 1 DIVU, 2 REM, 3 REMU
        add(2'd1, 0, 64'd100, 64'd7, 64'd14, 0);
        add(2'd3, 0, 64'd100, 64'd7, 64'd2, 0);
        add(2'd0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        add(2'd2, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 0);
        add(2'd0, 0, 64'd5, 64'd0, ONES, 1);
        add(2'd2, 0, 64'd5, 64'd0, 64'd5, 1);
        add(2'd0, 1, 64'h0000_0000_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1);
        add(2'd2, 1, 64'h0000_0000_8000_0000, ONES, 64'd0, 1);
        add(2'd0, 0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1);
        add(2'd2, 0, 64'h8000_0000_0000_0000, ONES, 64'd0, 1);
        add(2'd0, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, 0);
        add(2'd2, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
            64'hFFFF_FFFF_FFFF_FFFE, 0);
        add(2'd0, 0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 0);
        add(2'd2, 0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
        add(2'd0, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        add(2'd2, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, ONES, 0);
        add(2'd1, 1, 64'h0000_0001_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 0);
        add(2'd1, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, ONES, 0);
        add(2'd1, 0, ONES, 64'd10, 64'h1999_9999_9999_9999, 0);
        add(2'd3, 0, ONES, 64'd10, 64'd5, 0);
        add(2'd1, 1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, ONES, 1);
        add(2'd3, 1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000,
            64'hFFFF_FFFF_9ABC_DEF0, 1);
        add(2'd0, 0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, ONES, 1);
        add(2'd2, 0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1);

        // Reset state.
        repeat (2) @(negedge clk_i);
        check("reset busy", busy_o, 0);
        check("reset stall", stall_o, 0);
        check("reset done", done_o, 0);
        check("reset result", result_o, 0);
        rst_ni = 1;
        @(negedge clk_i);

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // Flush mid-op: no done, result untouched, then a new op right after.
        done_cnt = 0;
        op_i = 2'd1; word_i = 0; a_i = 64'd1000; b_i = 64'd3; start_i = 1;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            start_i = 0;
            if (done_o) done_cnt++;
        end
        flush_i = 1;
        @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 0;
        if (done_o) done_cnt++;
        check("flush busy", busy_o, 0);
        check("flush no_done", done_cnt, 0);
        check("flush result_unchanged", result_o, last_res);
        v.op = 2'd1; v.word = 0; v.a = 64'd9; v.b = 64'd3; v.exp = 64'd3; v.special = 0;
        run_op(v, "after_flush");

        // Flush and start together in idle: op not accepted.
        op_i = 2'd1; word_i = 0; a_i = 64'd50; b_i = 64'd5; start_i = 1; flush_i = 1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 0; flush_i = 0;
        check("flush_start busy", busy_o, 0);
        repeat (3) @(negedge clk_i);
        check("flush_start result_unchanged", result_o, last_res);

        // Async reset in the middle of CALC.
        op_i = 2'd1; word_i = 0; a_i = 64'd1000; b_i = 64'd3; start_i = 1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            start_i = 0;
        end
        check("pre_reset busy", busy_o, 1);
        rst_ni = 0;
        #1;
        check("midop_reset busy", busy_o, 0);
        check("midop_reset stall", stall_o, 0);
        check("midop_reset done", done_o, 0);
        check("midop_reset result", result_o, 0);
        last_res = '0;
        @(negedge clk_i);
        rst_ni = 1;
        @(negedge clk_i);
        v.op = 2'd1; v.word = 0; v.a = 64'd9; v.b = 64'd3; v.exp = 64'd3; v.special = 0;
        run_op(v, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
